shift_arbiter: RTL and testbench

//  Shares one combinational `shift` unit between NUM_REQ requesters with round-robin

---
 rtl/shift_arb_pkg.sv | 11 +
 rtl/shift.sv | 25 ++
 rtl/shift_rr_arbiter.sv | 32 +++
 rtl/shift_arbiter.sv | 127 ++++++++++++
 tb/tb_shift_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and defaults for the round-robin shift arbiter.
package shift_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } shift_arb_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/shift.sv
// Combinational logical shifter: sll when shope_i=1, srl when shope_i=0, zero fill.
module shift #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       operand_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   shope_i,
`ifdef SHIFT_ENABLE_PIN
  input  logic                   en_i,
`endif
  output logic [WIDTH-1:0]       result_o
);

  logic [WIDTH-1:0] shifted;

  assign shifted = shope_i ? (operand_i << shamt_i) : (operand_i >> shamt_i);

`ifdef SHIFT_ENABLE_PIN
  assign result_o = en_i ? shifted : '0;
`else
  assign result_o = shifted;
`endif

endmodule

// File: rtl/shift_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past ptr_i and wraps modulo NUM_REQ.
module shift_rr_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                any_o
);

  logic                found;
  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shift unit between NUM_REQ requesters; one result register feeds a single consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SHAMT_WIDTH = $clog2(WIDTH),
  parameter int NUM_REQ     = 2,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]       req_data,
  input  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt,
  input  logic [NUM_REQ-1:0]             req_shope,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WIDTH-1:0]               rsp_data,
  output logic [ID_WIDTH-1:0]            rsp_id
);

  shift_arb_state_t    state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_WIDTH-1:0]    win_idx;
  logic                   win_any;
  logic                   can_accept;
  logic                   accept;
  logic [WIDTH-1:0]       sel_data;
  logic [SHAMT_WIDTH-1:0] sel_shamt;
  logic                   sel_shope;
  logic [WIDTH-1:0]       shift_result;

  shift_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // The result register can take a new value when empty or when it drains this cycle.
  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign req_ready  = (rst_n && can_accept) ? grant : '0;
  assign accept     = rst_n & can_accept & win_any;

  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    sel_shope = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_WIDTH'(k)) begin
        sel_data  = req_data[k*WIDTH +: WIDTH];
        sel_shamt = req_shamt[k*SHAMT_WIDTH +: SHAMT_WIDTH];
        sel_shope = req_shope[k];
      end
    end
  end

  shift #(
    .WIDTH       (WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift (
    .operand_i (sel_data),
    .shamt_i   (sel_shamt),
    .shope_i   (sel_shope),
`ifdef SHIFT_ENABLE_PIN
    .en_i      (1'b1),
`endif
    .result_o  (shift_result)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      ptr_d      = win_idx;
      rsp_data_d = shift_result;
      rsp_id_d   = win_idx;
    end
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  // A requester still waiting for acceptance must not change its payload.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_payload_chk
    a_payload_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (req_valid[k] && !req_ready[k]) |=>
        (!req_valid[k] || ($stable(req_data[k*WIDTH +: WIDTH]) &&
                           $stable(req_shamt[k*SHAMT_WIDTH +: SHAMT_WIDTH]) &&
                           $stable(req_shope[k]))));
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter with four requesters: directed scenarios plus randomized traffic.
module tb_shift_arbiter;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0]  req_data = '0;
  logic [N*SW-1:0] req_shamt = '0;
  logic [N-1:0]  req_shope = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic [IW-1:0] rsp_id;

  shift_arbiter #(
    .WIDTH       (W),
    .SHAMT_WIDTH (SW),
    .NUM_REQ     (N),
    .ID_WIDTH    (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_shope (req_shope),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [IW+W-1:0] exp_q[$];
  int              m_ptr;
  bit              m_pend;

  logic [N-1:0]  obs_ready;
  logic          obs_rv;
  logic [W-1:0]  obs_rd;
  logic [IW-1:0] obs_rid;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh, input bit sll);
    logic [63:0] p;
    if (sll) begin
      p = {32'd0, d} * (64'd1 << sh);
      return p[W-1:0];
    end
    return d / (32'd1 << sh);
  endfunction

  function automatic int model_winner();
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = N - 1;
    m_pend = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input bit v, input logic [W-1:0] d, input int sh,
                         input bit sll);
    req_valid[k]             = v;
    req_data[k*W +: W]       = d;
    req_shamt[k*SW +: SW]    = SW'(sh);
    req_shope[k]             = sll;
  endtask

  task automatic rand_req(input int k);
    set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, W - 1),
            1'($urandom_range(0, 1)));
  endtask

  // Observe at the falling edge, compare with the model, then advance past the rising edge.
  task automatic step(output int acc);
    logic [N-1:0]    exp_ready;
    logic [IW+W-1:0] head;
    int              win;
    @(negedge clk);
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_rd    = rsp_data;
    obs_rid   = rsp_id;
    win       = model_winner();
    exp_ready = '0;
    if ((!m_pend || rsp_ready) && win >= 0) exp_ready[win] = 1'b1;
    check_eq("req_ready", 64'(obs_ready), 64'(exp_ready));
    check_eq("rsp_valid", 64'(obs_rv), 64'(m_pend));
    if (m_pend && rsp_ready) begin
      head = exp_q.pop_front();
      check_eq("rsp_data", 64'(obs_rd), 64'(head[W-1:0]));
      check_eq("rsp_id", 64'(obs_rid), 64'(head[IW+W-1:W]));
      m_pend = 1'b0;
    end
    acc = -1;
    if (exp_ready != '0) begin
      exp_q.push_back({IW'(win), ref_shift(req_data[win*W +: W],
                                           int'(req_shamt[win*SW +: SW]), req_shope[win])});
      m_pend = 1'b1;
      m_ptr  = win;
      acc    = win;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int g_exp2[4]  = '{0, 1, 0, 1};
    int r_exp2[4]  = '{864, 156, 864, 156};
    int id_exp6[5] = '{0, 1, 2, 3, 0};
    int g_exp6[4]  = '{3, 0, 1, 3};
    logic [W-1:0] b_d[4]   = '{32'h00FF_F000, 32'd4, 32'd3, 32'hDEAD_BEEF};
    int           b_sh[4]  = '{22, 9, 15, 0};
    bit           b_op[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] b_exp[4] = '{32'd0, 32'd0, 32'd98304, 32'hDEAD_BEEF};

    model_reset();

    // Reset state, with requests present while rst_n is low
    set_req(0, 1'b1, 32'd7, 1, 1'b1);
    set_req(1, 1'b1, 32'd9, 2, 1'b0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request
    set_req(0, 1'b1, 32'd3, 2, 1'b1);
    rsp_ready = 1'b1;
    step(acc);
    check_eq("t1_ready", 64'(obs_ready), 64'b0001);
    req_valid[0] = 1'b0;
    step(acc);
    check_eq("t1_rsp_valid", 64'(obs_rv), 64'd1);
    check_eq("t1_rsp_data", 64'(obs_rd), 64'd12);
    check_eq("t1_rsp_id", 64'(obs_rid), 64'd0);

    // Contention between two requesters
    do_reset();
    set_req(0, 1'b1, 32'd27, 5, 1'b1);
    set_req(1, 1'b1, 32'd10000, 6, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      check_eq("t2_grant", 64'(obs_ready), 64'd1 << g_exp2[i]);
      if (i > 0) check_eq("t2_result", 64'(obs_rd), 64'(r_exp2[i-1]));
    end
    req_valid = '0;
    step(acc);
    check_eq("t2_result", 64'(obs_rd), 64'(r_exp2[3]));

    // Backpressure with result 12 pending
    set_req(0, 1'b1, 32'd3, 2, 1'b1);
    rsp_ready = 1'b0;
    step(acc);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'd5, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(acc);
      check_eq("t3_hold_ready", 64'(obs_ready), 64'd0);
      check_eq("t3_hold_data", 64'(obs_rd), 64'd12);
      check_eq("t3_hold_valid", 64'(obs_rv), 64'd1);
    end
    rsp_ready = 1'b1;
    step(acc);
    check_eq("t3_refill_ready", 64'(obs_ready), 64'b0010);
    req_valid[1] = 1'b0;
    step(acc);
    check_eq("t3_refill_valid", 64'(obs_rv), 64'd1);
    check_eq("t3_refill_data", 64'(obs_rd), 64'd10);

    // Shift-amount boundaries
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, b_d[i], b_sh[i], b_op[i]);
      step(acc);
      req_valid[0] = 1'b0;
      step(acc);
      check_eq("t4_boundary", 64'(obs_rd), 64'(b_exp[i]));
    end

    // Reset while a result is pending and the pointer sits at 0
    do_reset();
    set_req(0, 1'b1, 32'd1, 1, 1'b1);
    rsp_ready = 1'b0;
    step(acc);
    set_req(0, 1'b1, 32'd8, 3, 1'b0);
    set_req(1, 1'b1, 32'd2, 4, 1'b1);
    check_eq("t5_pre_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", 64'(rsp_valid), 64'd0);
    check_eq("t5_async_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    rsp_ready = 1'b1;
    step(acc);
    check_eq("t5_req0_wins", 64'(obs_ready), 64'b0001);
    req_valid = '0;
    step(acc);

    // Fairness across four requesters, then with requester 2 withdrawn
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 32'(k + 1), k, 1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(acc);
      if (i > 0) check_eq("t6_rsp_id", 64'(obs_rid), 64'(id_exp6[i-1]));
    end
    req_valid[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      check_eq("t6_grant_no2", 64'(obs_ready), 64'd1 << g_exp6[i]);
    end
    req_valid = '0;
    step(acc);

    // Randomized traffic against the reference model
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 500; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      for (int k = 0; k < N; k++) begin
        if (acc == k || !req_valid[k]) rand_req(k);
      end
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) step(acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
